// File: rtl/led_pwm_fader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : led_pwm_fader                                                 |
// | Purpose  : N-channel LED PWM driver with OFF/SOLID/BLINK/BREATHE modes.  |
// |            Config writes land in per-channel shadow registers and are    |
// |            promoted at PWM period boundaries so outputs never glitch.    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module led_pwm_fader #(
   parameter  int N_CH      = 3,
   parameter  int PWM_W     = 8,
   parameter  int TICK_DIV  = 64,
   parameter  int BLINK_PER = 32,
   localparam int c_CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cfg_valid,
   output logic              o_cfg_ready,
   input  logic [c_CH_W-1:0] i_cfg_ch,
   input  logic [1:0]        i_cfg_mode,
   input  logic [PWM_W-1:0]  i_cfg_duty,
   output logic [N_CH-1:0]   o_led,
   output logic              o_period_stb
);

   localparam int               c_PS_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int               c_BL_W    = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
   localparam logic [PWM_W-1:0] c_PWM_MAX = {PWM_W{1'b1}};

   localparam logic [1:0] c_MODE_OFF     = 2'd0;
   localparam logic [1:0] c_MODE_SOLID   = 2'd1;
   localparam logic [1:0] c_MODE_BLINK   = 2'd2;
   localparam logic [1:0] c_MODE_BREATHE = 2'd3;

   localparam logic [0:0] c_ST_RISE = 1'b0;
   localparam logic [0:0] c_ST_FALL = 1'b1;

   logic [c_PS_W-1:0] r_presc;
   logic [PWM_W-1:0]  r_pwm_cnt;
   logic              r_ready;
   logic [N_CH-1:0]   r_led;
   logic              w_tick;
   logic              w_bound;
   logic              w_acc;
   logic [PWM_W-1:0]  w_level [N_CH];

   assign w_tick       = (r_presc == c_PS_W'(TICK_DIV - 1));
   assign w_bound      = w_tick && (r_pwm_cnt == c_PWM_MAX);
   assign w_acc        = i_cfg_valid && r_ready;
   assign o_cfg_ready  = r_ready;
   assign o_period_stb = w_bound;
   assign o_led        = r_led;

   // Prescaler and PWM phase counter forming the shared timing base
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_presc   <= '0;
         r_pwm_cnt <= '0;
      end else if (w_tick) begin
         r_presc   <= '0;
         r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
      end else begin
         r_presc   <= r_presc + c_PS_W'(1);
      end
   end

   // Config port is ready every cycle outside reset
   always_ff @(posedge i_clk) begin
      if (i_rst) r_ready <= 1'b0;
      else       r_ready <= 1'b1;
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         // The active duty is not stored separately: it is fully reflected
         // in r_level, which is recomputed from the shadow at each boundary.
         logic [1:0]        r_sh_mode;
         logic [PWM_W-1:0]  r_sh_duty;
         logic [1:0]        r_act_mode;
         logic [PWM_W-1:0]  r_level;
         logic [c_BL_W-1:0] r_blink_cnt;
         logic              r_phase;
         logic [0:0]        r_brth_st;
         logic              w_wr;
         logic              w_mode_chg;
         logic [PWM_W:0]    w_inc;
         logic [PWM_W-1:0]  w_lvl_nxt;
         logic [c_BL_W-1:0] w_cnt_nxt;
         logic              w_ph_nxt;
         logic [0:0]        w_st_nxt;

         assign w_wr         = w_acc && (i_cfg_ch == c_CH_W'(gi));
         assign w_mode_chg   = (r_sh_mode != r_act_mode);
         assign w_inc        = {1'b0, r_level} + {{PWM_W{1'b0}}, 1'b1};
         assign w_level[gi]  = r_level;

         // Next-period level, blink and breathe state, evaluated on the shadow values
         always_comb begin
            w_lvl_nxt = r_level;
            w_cnt_nxt = r_blink_cnt;
            w_ph_nxt  = r_phase;
            w_st_nxt  = r_brth_st;
            if (w_mode_chg) begin
               w_cnt_nxt = '0;
               w_ph_nxt  = 1'b1;
            end else if (r_sh_mode == c_MODE_BLINK) begin
               if (r_blink_cnt == c_BL_W'(BLINK_PER - 1)) begin
                  w_cnt_nxt = '0;
                  w_ph_nxt  = ~r_phase;
               end else begin
                  w_cnt_nxt = r_blink_cnt + c_BL_W'(1);
               end
            end
            case (r_sh_mode)
               c_MODE_OFF:   w_lvl_nxt = '0;
               c_MODE_SOLID: w_lvl_nxt = r_sh_duty;
               c_MODE_BLINK: w_lvl_nxt = w_ph_nxt ? r_sh_duty : '0;
               default: begin
                  if (w_mode_chg) begin
                     w_lvl_nxt = '0;
                     w_st_nxt  = c_ST_RISE;
                  end else if (r_sh_duty < r_level) begin
                     w_lvl_nxt = r_sh_duty;
                     w_st_nxt  = c_ST_FALL;
                  end else if (r_brth_st == c_ST_RISE) begin
                     // Increment in PWM_W+1 bits so a peak of all-ones cannot wrap
                     if (w_inc >= {1'b0, r_sh_duty}) begin
                        w_lvl_nxt = r_sh_duty;
                        w_st_nxt  = c_ST_FALL;
                     end else begin
                        w_lvl_nxt = w_inc[PWM_W-1:0];
                     end
                  end else if (r_level <= PWM_W'(1)) begin
                     w_lvl_nxt = '0;
                     w_st_nxt  = c_ST_RISE;
                  end else begin
                     w_lvl_nxt = r_level - PWM_W'(1);
                  end
               end
            endcase
         end

         // Shadow capture on handshake; shadow-to-active promotion at boundaries
         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_sh_mode   <= c_MODE_OFF;
               r_sh_duty   <= '0;
               r_act_mode  <= c_MODE_OFF;
               r_level     <= '0;
               r_blink_cnt <= '0;
               r_phase     <= 1'b0;
               r_brth_st   <= c_ST_RISE;
            end else begin
               if (w_bound) begin
                  r_act_mode  <= r_sh_mode;
                  r_level     <= w_lvl_nxt;
                  r_blink_cnt <= w_cnt_nxt;
                  r_phase     <= w_ph_nxt;
                  r_brth_st   <= w_st_nxt;
               end
               if (w_wr) begin
                  r_sh_mode <= i_cfg_mode;
                  r_sh_duty <= i_cfg_duty;
               end
            end
         end
      end
   endgenerate

   // Registered PWM comparator per channel
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_led <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            r_led[c] <= (r_pwm_cnt < w_level[c]);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_led_pwm_fader.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_led_pwm_fader                                              |
// | Purpose  : Self-checking bench for led_pwm_fader against a period-level  |
// |            reference model, directed scenarios plus random traffic.      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_led_pwm_fader;
   localparam int N_CH      = 3;
   localparam int PWM_W     = 4;
   localparam int TICK_DIV  = 1;
   localparam int BLINK_PER = 2;
   localparam int PER       = 16;

   logic             clk = 1'b0;
   logic             i_rst = 1'b1;
   logic             i_cfg_valid = 1'b0;
   logic             o_cfg_ready;
   logic [1:0]       i_cfg_ch = '0;
   logic [1:0]       i_cfg_mode = '0;
   logic [PWM_W-1:0] i_cfg_duty = '0;
   logic [N_CH-1:0]  o_led;
   logic             o_period_stb;

   always #5 clk = ~clk;

   led_pwm_fader #(
      .N_CH(N_CH), .PWM_W(PWM_W), .TICK_DIV(TICK_DIV), .BLINK_PER(BLINK_PER)
   ) dut (
      .i_clk(clk), .i_rst(i_rst), .i_cfg_valid(i_cfg_valid), .o_cfg_ready(o_cfg_ready),
      .i_cfg_ch(i_cfg_ch), .i_cfg_mode(i_cfg_mode), .i_cfg_duty(i_cfg_duty),
      .o_led(o_led), .o_period_stb(o_period_stb)
   );

   // Reference model: period position, shadow/active config, level per channel
   int              checks = 0;
   int              errors = 0;
   int              m_cnt;
   bit              m_ready;
   bit              m_stb = 1'b0;
   logic [N_CH-1:0] m_led;
   int              sh_mode [N_CH];
   int              sh_duty [N_CH];
   int              act_mode[N_CH];
   int              lvl     [N_CH];
   int              nb      [N_CH];
   bit              rising  [N_CH];
   int              win_cnt [N_CH];
   int              win_last[N_CH];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt   = 0;
      m_ready = 1'b0;
      m_led   = '0;
      for (int c = 0; c < N_CH; c++) begin
         sh_mode[c] = 0; sh_duty[c] = 0; act_mode[c] = 0;
         lvl[c] = 0; nb[c] = 0; rising[c] = 1'b1; win_cnt[c] = 0;
      end
   endtask

   // Level for the coming period, from the rules for each mode
   task automatic apply_boundary(input int c);
      bit chg;
      int d;
      chg         = (sh_mode[c] != act_mode[c]);
      act_mode[c] = sh_mode[c];
      d           = sh_duty[c];
      nb[c]       = chg ? 0 : nb[c] + 1;
      case (act_mode[c])
         0: lvl[c] = 0;
         1: lvl[c] = d;
         2: lvl[c] = (((nb[c] / BLINK_PER) % 2) == 0) ? d : 0;
         default: begin
            if (chg) begin
               lvl[c] = 0; rising[c] = 1'b1;
            end else if (d < lvl[c]) begin
               lvl[c] = d; rising[c] = 1'b0;
            end else if (rising[c]) begin
               if (lvl[c] + 1 >= d) begin lvl[c] = d; rising[c] = 1'b0; end
               else lvl[c] = lvl[c] + 1;
            end else begin
               if (lvl[c] <= 1) begin lvl[c] = 0; rising[c] = 1'b1; end
               else lvl[c] = lvl[c] - 1;
            end
         end
      endcase
   endtask

   // One clock: advance the model over the edge, then compare outputs
   task automatic step();
      bit rst_in, acc, bnd;
      int pre_cnt, wch, wmode, wduty;
      int pre_lvl[N_CH];
      rst_in  = i_rst;
      acc     = i_cfg_valid && m_ready;
      bnd     = m_stb;
      pre_cnt = m_cnt;
      pre_lvl = lvl;
      wch     = int'(i_cfg_ch);
      wmode   = int'(i_cfg_mode);
      wduty   = int'(i_cfg_duty);
      @(posedge clk);
      #1;
      if (rst_in) begin
         model_reset();
      end else begin
         for (int c = 0; c < N_CH; c++) m_led[c] = (pre_cnt < pre_lvl[c]);
         if (bnd) for (int c = 0; c < N_CH; c++) apply_boundary(c);
         if (acc && wch < N_CH) begin
            sh_mode[wch] = wmode;
            sh_duty[wch] = wduty;
         end
         m_cnt   = (m_cnt + 1) % PER;
         m_ready = 1'b1;
      end
      m_stb = (m_cnt == PER - 1);
      chk("led", o_led, m_led);
      chk("period_stb", o_period_stb, m_stb);
      chk("cfg_ready", o_cfg_ready, m_ready);
      for (int c = 0; c < N_CH; c++) win_cnt[c] += int'(o_led[c]);
      if (m_stb) begin
         for (int c = 0; c < N_CH; c++) begin
            chk("period_on_count", win_cnt[c], lvl[c]);
            win_last[c] = win_cnt[c];
            win_cnt[c]  = 0;
         end
      end
   endtask

   task automatic wait_stb(output int n);
      n = 0;
      for (int i = 0; i < 4 * PER; i++) begin
         step();
         n++;
         if (m_stb) return;
      end
      errors++;
      $error("FAIL wait_stb observed=timeout expected=boundary within %0d cycles", 4 * PER);
   endtask

   task automatic cfg_write(input int ch, input int mode, input int duty);
      i_cfg_valid = 1'b1;
      i_cfg_ch    = 2'(ch);
      i_cfg_mode  = 2'(mode);
      i_cfg_duty  = PWM_W'(duty);
      step();
      i_cfg_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int blink_pat[8];
      int brth_pat[8];
      blink_pat = '{15, 15, 0, 0, 15, 15, 0, 0};
      brth_pat  = '{0, 1, 2, 3, 2, 1, 0, 1};
      model_reset();

      // Reset held three cycles, then idle: LEDs dark, strobe every 16 cycles
      i_rst = 1'b1;
      repeat (3) step();
      chk("t1_rst_ready", o_cfg_ready, 0);
      i_rst = 1'b0;
      step();
      chk("t1_ready_after_rst", o_cfg_ready, 1);
      wait_stb(n);
      wait_stb(n);
      chk("t1_stb_period", n, 16);
      for (int c = 0; c < N_CH; c++) chk("t1_dark", win_last[c], 0);

      // SOLID duty 5, written in a boundary cycle: takes effect one period later
      wait_stb(n);
      cfg_write(0, 1, 5);
      wait_stb(n);
      chk("t2_bnd_write_deferred", win_last[0], 0);
      wait_stb(n);
      chk("t2_solid5_a", win_last[0], 5);
      wait_stb(n);
      chk("t2_solid5_b", win_last[0], 5);

      // BLINK duty 15: two periods on, two off
      wait_stb(n);
      cfg_write(1, 2, 15);
      wait_stb(n);
      for (int k = 0; k < 8; k++) begin
         wait_stb(n);
         chk("t3_blink", win_last[1], blink_pat[k]);
      end

      // BREATHE peak 3, then lower the peak to 1 while at level 3
      wait_stb(n);
      cfg_write(2, 3, 3);
      wait_stb(n);
      for (int k = 0; k < 8; k++) begin
         wait_stb(n);
         chk("t4_breathe", win_last[2], brth_pat[k]);
      end
      wait_stb(n);
      chk("t4_breathe_2", win_last[2], 2);
      repeat (3) step();
      cfg_write(2, 3, 1);
      wait_stb(n);
      chk("t4_breathe_3", win_last[2], 3);
      wait_stb(n);
      chk("t4_lowered_1", win_last[2], 1);
      wait_stb(n);
      chk("t4_lowered_0", win_last[2], 0);
      wait_stb(n);
      chk("t4_lowered_1b", win_last[2], 1);

      // Two writes to ch0 in one period (last wins) plus an out-of-range channel
      wait_stb(n);
      repeat (2) step();
      cfg_write(0, 1, 4);
      cfg_write(0, 1, 9);
      cfg_write(3, 1, 2);
      chk("t5_ready_ch3", o_cfg_ready, 1);
      wait_stb(n);
      wait_stb(n);
      chk("t5_last_wins", win_last[0], 9);

      // Reset in the middle of breathing: everything dark and OFF afterwards
      repeat (3) step();
      i_rst = 1'b1;
      step();
      chk("t6_rst_led", o_led, 0);
      chk("t6_rst_ready", o_cfg_ready, 0);
      step();
      i_rst = 1'b0;
      step();
      repeat (3) wait_stb(n);
      for (int c = 0; c < N_CH; c++) chk("t6_off_after_rst", win_last[c], 0);

      // Random traffic including out-of-range channels and occasional resets
      for (int i = 0; i < 4000; i++) begin
         i_rst       = ($urandom_range(0, 599) == 0);
         i_cfg_valid = ($urandom_range(0, 3) == 0);
         i_cfg_ch    = 2'($urandom_range(0, 3));
         i_cfg_mode  = 2'($urandom_range(0, 3));
         i_cfg_duty  = PWM_W'($urandom_range(0, 15));
         step();
      end
      i_rst       = 1'b0;
      i_cfg_valid = 1'b0;
      repeat (40) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
